// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the instruction decode stage.
interface instr_decode_stage_if #(
  parameter int PC_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [3:0]      out_op;
  logic [3:0]      out_rd;
  logic [3:0]      out_rs;
  logic [3:0]      out_rt;
  logic [7:0]      out_imm;
  logic            out_imm_sw;
  logic            out_imm_sext;
  logic            out_has_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rd, out_rs, out_rt,
           out_imm, out_imm_sw, out_imm_sext, out_has_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs, out_rt,
           out_imm, out_imm_sw, out_imm_sext, out_has_imm, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered decode stage: splits a 16-bit instruction into fields and extender
// controls, buffers results in a 2-entry skid FIFO, and stops issue after HALT.
module instr_decode_stage #(
  parameter int         PC_W    = 16,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  instr_decode_stage_if.slave   bus
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [3:0]      op;
    logic [3:0]      rd;
    logic [3:0]      rs;
    logic [3:0]      rt;
    logic [7:0]      imm;
    logic            sw;
    logic            sext;
    logic            has_imm;
    logic            illegal;
  } entry_t;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  entry_t     dec;
  entry_t     slot0_q, slot0_d;
  entry_t     slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  state_t     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       push, pop;

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.op      = bus.in_instr[15:12];
    dec.rd      = bus.in_instr[11:8];
    dec.rs      = bus.in_instr[7:4];
    dec.rt      = bus.in_instr[3:0];
    dec.imm     = bus.in_instr[7:0];
    case (bus.in_instr[15:12])
      4'h1, 4'h2, 4'h3, 4'hC, 4'hD: begin
        dec.sext    = 1'b1;
        dec.has_imm = 1'b1;
      end
      4'h4, 4'h5: dec.has_imm = 1'b1;
      4'h8, 4'hA, 4'hB: begin
        dec.sw      = 1'b1;
        dec.sext    = 1'b1;
        dec.has_imm = 1'b1;
      end
      4'h9: begin
        dec.sw      = 1'b1;
        dec.has_imm = 1'b1;
      end
      4'h6, 4'h7: dec.illegal = 1'b1;
      default: ;
    endcase
  end

  assign push = bus.in_valid && in_ready_q;
  assign pop  = (count_q != 2'd0) && bus.out_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      slot0_d = '0;
      slot1_d = '0;
      count_d = 2'd0;
      state_d = ST_RUN;
    end else begin
      // in_ready_q implies count_q < 2, so push never overflows; push+pop only occurs with one entry held
      if (push && pop) begin
        slot0_d = dec;
      end else if (push) begin
        if (count_q == 2'd0) slot0_d = dec;
        else                 slot1_d = dec;
        count_d = count_q + 2'd1;
      end else if (pop) begin
        slot0_d = slot1_q;
        slot1_d = '0;
        count_d = count_q - 2'd1;
      end
      if (push && dec.op == HALT_OP) state_d = ST_HALTED;
    end
    in_ready_d = (count_d < 2'd2) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      count_q    <= 2'd0;
      state_q    <= ST_RUN;
      in_ready_q <= 1'b0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      count_q    <= count_d;
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.out_pc       = slot0_q.pc;
  assign bus.out_op       = slot0_q.op;
  assign bus.out_rd       = slot0_q.rd;
  assign bus.out_rs       = slot0_q.rs;
  assign bus.out_rt       = slot0_q.rt;
  assign bus.out_imm      = slot0_q.imm;
  assign bus.out_imm_sw   = slot0_q.sw;
  assign bus.out_imm_sext = slot0_q.sext;
  assign bus.out_has_imm  = slot0_q.has_imm;
  assign bus.out_illegal  = slot0_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: opcode table vectors plus FIFO, halt,
// flush and reset sequences.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  instr_decode_stage_if #(.PC_W(16)) bus ();

  instr_decode_stage #(.PC_W(16), .HALT_OP(4'hF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [7:0]  imm;
    logic        sw;
    logic        sext;
    logic        has_imm;
    logic        illegal;
    logic [15:0] ext;
  } vec_t;

  localparam int N_VEC  = 18;
  localparam int N_LOOP = 16;
  localparam int V_8AF3 = 1, V_152C = 2, V_4A2C = 3, V_2345 = 4, V_9280 = 9;
  localparam int V_E500 = 14, V_1111 = 15, V_F000 = 16, V_0123 = 0, V_B181 = 11;

  vec_t vec [N_VEC];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Downstream extender model: 4-bit or 8-bit field, sign or zero extended to 16 bits.
  function automatic logic [15:0] ext16(input logic [7:0] imm, input logic sw, input logic sext);
    logic [15:0] r;
    if (sw) r = sext ? {{8{imm[7]}}, imm} : {8'h00, imm};
    else    r = sext ? {{12{imm[3]}}, imm[3:0]} : {12'h000, imm[3:0]};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string nm, input int i);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, ".pc"},    32'(bus.out_pc), 32'(vec[i].pc));
    chk({nm, ".op"},    32'(bus.out_op), 32'(vec[i].op));
    chk({nm, ".rd"},    32'(bus.out_rd), 32'(vec[i].rd));
    chk({nm, ".rs"},    32'(bus.out_rs), 32'(vec[i].rs));
    chk({nm, ".rt"},    32'(bus.out_rt), 32'(vec[i].rt));
    chk({nm, ".imm"},   32'(bus.out_imm), 32'(vec[i].imm));
    chk({nm, ".sw"},    32'(bus.out_imm_sw), 32'(vec[i].sw));
    chk({nm, ".sext"},  32'(bus.out_imm_sext), 32'(vec[i].sext));
    chk({nm, ".hasimm"},32'(bus.out_has_imm), 32'(vec[i].has_imm));
    chk({nm, ".ill"},   32'(bus.out_illegal), 32'(vec[i].illegal));
    chk({nm, ".ext"},   32'(ext16(bus.out_imm, bus.out_imm_sw, bus.out_imm_sext)), 32'(vec[i].ext));
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, ".data"},  {bus.out_pc, bus.out_op, bus.out_rd, bus.out_rs, bus.out_rt}, 32'd0);
    chk({nm, ".flags"}, {20'd0, bus.out_imm, bus.out_imm_sw, bus.out_imm_sext,
                         bus.out_has_imm, bus.out_illegal}, 32'd0);
  endtask

  task automatic drive(input int i);
    bus.in_valid = 1'b1;
    bus.in_instr = vec[i].instr;
    bus.in_pc    = vec[i].pc;
  endtask

  initial begin
    //        instr     pc       op    rd    rs    rt    imm    sw sx hi il ext
    vec[0]  = '{16'h0123, 16'h0100, 4'h0, 4'h1, 4'h2, 4'h3, 8'h23, 0, 0, 0, 0, 16'h0003};
    vec[1]  = '{16'h8AF3, 16'h0010, 4'h8, 4'hA, 4'hF, 4'h3, 8'hF3, 1, 1, 1, 0, 16'hFFF3};
    vec[2]  = '{16'h152C, 16'h0012, 4'h1, 4'h5, 4'h2, 4'hC, 8'h2C, 0, 1, 1, 0, 16'hFFFC};
    vec[3]  = '{16'h4A2C, 16'h0014, 4'h4, 4'hA, 4'h2, 4'hC, 8'h2C, 0, 0, 1, 0, 16'h000C};
    vec[4]  = '{16'h2345, 16'h0016, 4'h2, 4'h3, 4'h4, 4'h5, 8'h45, 0, 1, 1, 0, 16'h0005};
    vec[5]  = '{16'h3FF8, 16'h0018, 4'h3, 4'hF, 4'hF, 4'h8, 8'hF8, 0, 1, 1, 0, 16'hFFF8};
    vec[6]  = '{16'h5107, 16'h001A, 4'h5, 4'h1, 4'h0, 4'h7, 8'h07, 0, 0, 1, 0, 16'h0007};
    vec[7]  = '{16'h6123, 16'h001C, 4'h6, 4'h1, 4'h2, 4'h3, 8'h23, 0, 0, 0, 1, 16'h0003};
    vec[8]  = '{16'h7ABC, 16'h001E, 4'h7, 4'hA, 4'hB, 4'hC, 8'hBC, 0, 0, 0, 1, 16'h000C};
    vec[9]  = '{16'h9280, 16'h0020, 4'h9, 4'h2, 4'h8, 4'h0, 8'h80, 1, 0, 1, 0, 16'h0080};
    vec[10] = '{16'hA07F, 16'h0022, 4'hA, 4'h0, 4'h7, 4'hF, 8'h7F, 1, 1, 1, 0, 16'h007F};
    vec[11] = '{16'hB181, 16'h0024, 4'hB, 4'h1, 4'h8, 4'h1, 8'h81, 1, 1, 1, 0, 16'hFF81};
    vec[12] = '{16'hC3F9, 16'h0026, 4'hC, 4'h3, 4'hF, 4'h9, 8'hF9, 0, 1, 1, 0, 16'hFFF9};
    vec[13] = '{16'hD44E, 16'h0028, 4'hD, 4'h4, 4'h4, 4'hE, 8'h4E, 0, 1, 1, 0, 16'hFFFE};
    vec[14] = '{16'hE500, 16'h002A, 4'hE, 4'h5, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 16'h0000};
    vec[15] = '{16'h1111, 16'h002C, 4'h1, 4'h1, 4'h1, 4'h1, 8'h11, 0, 1, 1, 0, 16'h0001};
    vec[16] = '{16'hF000, 16'h0030, 4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, 16'h0000};
    vec[17] = '{16'h1111, 16'h0032, 4'h1, 4'h1, 4'h1, 4'h1, 8'h11, 0, 1, 1, 0, 16'h0001};

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check_zero("rst");
    rst_n = 1'b1;
    step();
    chk("rel.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel.out_valid", 32'(bus.out_valid), 32'd0);

    // Opcode table: one instruction at a time, drained immediately
    for (int i = 0; i < N_LOOP; i++) begin
      drive(i);
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      check_vec($sformatf("v%0d", i), i);
      step();
      chk($sformatf("v%0d.drained", i), 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back issue with a ready consumer
    drive(V_152C);
    step();
    check_vec("b2b.first", V_152C);
    chk("b2b.in_ready", 32'(bus.in_ready), 32'd1);
    drive(V_4A2C);
    step();
    bus.in_valid = 1'b0;
    check_vec("b2b.second", V_4A2C);
    step();
    chk("b2b.empty", 32'(bus.out_valid), 32'd0);

    // Stalled consumer: only two entries accepted, head stable, FIFO order on release
    bus.out_ready = 1'b0;
    drive(V_2345);
    step();
    drive(V_9280);
    step();
    chk("stall.full_ready", 32'(bus.in_ready), 32'd0);
    drive(V_E500);
    step();
    step();
    check_vec("stall.head_hold", V_2345);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check_vec("stall.second", V_9280);
    chk("stall.ready_back", 32'(bus.in_ready), 32'd1);
    step();
    chk("stall.empty", 32'(bus.out_valid), 32'd0);

    // HALT stops intake; buffered HALT still drains; flush resumes
    drive(V_F000);
    step();
    check_vec("halt.out", V_F000);
    chk("halt.in_ready", 32'(bus.in_ready), 32'd0);
    drive(V_1111);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("halt.blocked%0d.valid", c), 32'(bus.out_valid), 32'd0);
      chk($sformatf("halt.blocked%0d.ready", c), 32'(bus.in_ready), 32'd0);
    end
    drive(17);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halt.flush_ready", 32'(bus.in_ready), 32'd1);
    chk("halt.flush_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check_vec("halt.resume", 17);
    step();

    // Flush with two entries held and a simultaneous offer
    bus.out_ready = 1'b0;
    drive(V_0123);
    step();
    drive(V_8AF3);
    step();
    drive(V_B181);
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check_zero("flush2");
    chk("flush2.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("flush2.nothing", 32'(bus.out_valid), 32'd0);

    // Same with reset instead of flush
    drive(V_0123);
    step();
    drive(V_8AF3);
    step();
    drive(V_B181);
    rst_n = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check_zero("rst2");
    chk("rst2.in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst2.rel_ready", 32'(bus.in_ready), 32'd1);
    check_zero("rst2.rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered decode stage directly upstream of the immediate sign/zero extension units.
- Accepts a fetched 16-bit instruction plus PC over a valid/ready handshake and splits it into opcode and register fields.
- Drives the extenders' 8-bit immediate input, width select (sw) and a signed/unsigned select.
- A 2-entry skid buffer decouples fetch from execute; a small FSM stops issue after HALT until flush.

Parameters:
- PC_W, 16, width of the PC carried alongside the instruction.
- HALT_OP, 4'hF, opcode that stops the stage.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline flush; also clears HALTED
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  16  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of decoded entry
- out_op  out  4  instr[15:12]
- out_rd  out  4  instr[11:8]
- out_rs  out  4  instr[7:4]
- out_rt  out  4  instr[3:0]
- out_imm  out  8  instr[7:0]; feeds extender I
- out_imm_sw  out  1  1 = 8-bit immediate, 0 = 4-bit (instr[3:0]); feeds extender sw
- out_imm_sext  out  1  1 = use sign extension, 0 = zero extension
- out_has_imm  out  1  instruction uses an immediate
- out_illegal  out  1  undefined opcode

Behaviour:
- Opcode table, as (sw, sext, has_imm):
  - 0x0 R-type: (0, 0, 0)
  - 0x1–0x3 ADDI/SUBI/CMPI: (0, 1, 1)
  - 0x4–0x5 ANDI/SHI: (0, 0, 1)
  - 0x8 LI: (1, 1, 1)
  - 0x9 LUI: (1, 0, 1)
  - 0xA–0xB branches: (1, 1, 1)
  - 0xC LD / 0xD ST: (0, 1, 1)
  - 0xE JR: (0, 0, 0)
  - 0xF HALT: (0, 0, 0)
  - 0x6, 0x7: illegal=1, all other flags 0.
  - Entries are otherwise passed through unchanged.
- Decode is combinational on the input word; results are stored in the buffer, so all out_* are registered.
- Latency: an accepted instruction appears on out_* the next cycle when the buffer is empty.
- Buffer: 2 entries, head presented on out_*.
  - in_ready is registered: 1 when fewer than 2 entries are held at cycle end, state is RUN, and no flush.
  - Accept when in_valid && in_ready; pop when out_valid && out_ready.
  - Simultaneous push and pop with 1 entry held: count stays 1, the new entry becomes head next cycle.
  - With 2 entries held, pop only; in_ready rises the following cycle.
  - Order is strictly FIFO, with no loss or duplication.
- out_* data holds stable while out_valid && !out_ready.
- FSM:
  - RUN → HALTED when a HALT_OP instruction is accepted.
  - In HALTED, in_ready=0; already-buffered entries, including the HALT, still drain.
  - HALTED → RUN only on flush.
  - Illegal opcodes do not halt; they are flagged only.
- flush: next cycle the buffer is empty, out_valid=0, in_ready=1, state is RUN. An in-flight handshake in the flush cycle is discarded. flush has priority over push, pop and the HALT transition.
- Reset (rst_n low at clk edge):
  - Buffer empty, state RUN.
  - out_valid=0, in_ready=0 during reset, 1 on the first cycle after release.
  - All out_* data fields 0, including illegal/sw/sext/has_imm.
  - Reset mid-transfer drops all entries.
- No X propagation: unused buffer slots hold 0.

Test Plan:
- Reset release, then push 0x8AF3 at PC 0x0010 with out_ready=1 → next cycle out_valid=1, op=8, rd=A, imm=F3, sw=1, sext=1, has_imm=1; downstream extender yields 0xFFF3.
- Push 0x152C then 0x4A2C → first: sw=0, sext=1, rt=C (extender 0xFFFC); second: sext=0 (extender 0x000C); in order, one per cycle.
- out_ready=0, push 3 instructions back-to-back → only 2 accepted, in_ready=0 after the second; raise out_ready → both emerge in order, data stable while stalled, in_ready returns.
- Push 0xF000 then 0x1111 → HALT accepted and emitted, in_ready stays 0, 0x1111 never accepted; assert flush → in_ready=1 next cycle and 0x1111 is accepted.
- Push 0x6123 → illegal=1, has_imm=0, state remains RUN.
- Two entries held, assert flush and in_valid together → next cycle out_valid=0 and nothing accepted; repeat with rst_n=0 → all outputs 0.
